// File: rtl/_latch_tx.sv
`default_nettype none
// _latch_tx (rev 1.0): MSB-first serial transmitter with SETUP/STROBE/HOLD framing per bit for D-latch capture.
// Define LATCH_TX_PARITY_EN to append an even-parity bit after the data LSB.
module _latch_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             d_out,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

`ifdef LATCH_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           d_out_q, d_out_d;
  logic           strobe_q, strobe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ready_q, ready_d;
  logic [N-1:0]   w_load_word;

`ifdef LATCH_TX_PARITY_EN
  assign w_load_word = {load_data, ^load_data};
`else
  assign w_load_word = load_data;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          shift_d = w_load_word;
          cnt_d   = C_LAST;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - CW'(1);
          state_d = S_SETUP;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops;
    // the shift register only moves on HOLD->SETUP, keeping d_out still around strobe.
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    strobe_d = (state_d == S_STROBE);
    done_d   = (state_d == S_DONE);
    d_out_d  = ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD))
               ? shift_d[N-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      d_out_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      d_out_q  <= d_out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign d_out      = d_out_q;
  assign strobe     = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb__latch_tx.sv
`default_nettype none
// tb__latch_tx: scoreboard bench for _latch_tx; expected bits/done cycles queued at accept, popped by a monitor.
module tb__latch_tx;
  localparam int WIDTH = 8;
`ifdef LATCH_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready, d_out, strobe, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0      = 0;

  typedef struct {
    logic b;
    int   c;
  } bit_exp_t;

  bit_exp_t bq[$];
  int       dq[$];
  logic     strobe_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  _latch_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .d_out      (d_out),
    .strobe     (strobe),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] frame(input logic [WIDTH-1:0] w);
`ifdef LATCH_TX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Monitor: the receiver's view, capturing d_out when strobe has just fallen.
  always @(negedge clk) begin
    bit_exp_t e;
    if (!reset_n) begin
      strobe_prev = 1'b0;
    end else begin
      if (strobe_prev && !strobe) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_strobe: got strobe fall at cycle %0d expected none", cyc);
        end else begin
          e = bq.pop_front();
          check("bit_value", {31'd0, d_out}, {31'd0, e.b});
          check("bit_cycle", cyc, e.c);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          check("done_cycle", cyc, dq.pop_front());
        end
      end
      strobe_prev = strobe;
    end
  end

  task automatic wait_ready(output int at);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (load_ready) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got no load_ready within 200 cycles expected ready");
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input bit keep, input int exp_at);
    int at;
    logic [N-1:0] word;
    wait_ready(at);
    if (exp_at >= 0) check("accept_cycle", at, exp_at);
    load_valid = 1'b1;
    load_data  = w;
    c0 = at;
    word = frame(w);
    for (int i = 0; i < N; i++) bq.push_back('{word[N-1-i], c0 + 3*i + 3});
    dq.push_back(c0 + 3*N + 1);
    @(posedge clk);
    #1;
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, load_ready}, 32'd1);
    check({tag, "_busy"},   {31'd0, busy},       32'd0);
    check({tag, "_strobe"}, {31'd0, strobe},     32'd0);
    check({tag, "_d_out"},  {31'd0, d_out},      32'd0);
    check({tag, "_done"},   {31'd0, done},       32'd0);
  endtask

  initial begin
    int t;
    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 0xA5 single word, then 0x3C/0xC3 back-to-back with valid held.
    send(8'hA5, 1'b0, -1);
    t = c0; send(8'h3C, 1'b1, t + 3*N + 2);
    t = c0; send(8'hC3, 1'b1, t + 3*N + 2);
    load_valid = 1'b0;

    // 0x00 with a 0xFF offer during cycles 5..10 that must be ignored.
    t = c0; send(8'h00, 1'b0, t + 3*N + 2);
    repeat (5) @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'd1);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (6) @(negedge clk);
    check("ready_mid", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;

    // Reset in cycle 10 of a 0xF0 transfer, released in cycle 12.
    t = c0; send(8'hF0, 1'b0, t + 3*N + 2);
    repeat (10) @(negedge clk);
    check("pre_reset_d_out", {31'd0, d_out}, 32'd1);
    #1 reset_n = 1'b0;
    bq.delete();
    dq.delete();
    #1 check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    send(8'h81, 1'b0, -1);
`ifdef LATCH_TX_PARITY_EN
    t = c0; send(8'h07, 1'b0, t + 3*N + 2);
    t = c0; send(8'hA5, 1'b0, t + 3*N + 2);
`endif
    wait_ready(t);
    check("final_ready_cycle", t, c0 + 3*N + 2);
    repeat (3) @(negedge clk);
    check("bits_drained", bq.size(), 32'd0);
    check("done_drained", dq.size(), 32'd0);
    check_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
